dec_unbinder_stream: RTL and testbench
======================================

DEC_UNBINDER_STREAM -- requirements
Module: dec_unbinder_stream

Interface
REQ-001 The block SHALL have parameter HV_DIM, default 2048, giving the hypervector width in bits.
REQ-002 The block SHALL have parameter FEATURES_PER_CC, default 8, giving the number of features per frame.
REQ-003 The block SHALL have parameter SHIFT_BASE, default 0, giving the index of feature 0 in the package-level SHIFTS table.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port frame_clr, input, 1 bit: synchronous frame restart.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-009 The block SHALL have port in_hv, input, HV_DIM bits: the bound (shifted) hypervector.
REQ-010 The block SHALL have port out_valid, output, 1 bit: an output beat is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the output beat.
REQ-012 The block SHALL have port out_hv, output, HV_DIM bits: the recovered level hypervector.
REQ-013 The block SHALL have port out_feat, output, clog2(FEATURES_PER_CC) bits: the feature index of out_hv.
REQ-014 The block SHALL have port out_last, output, 1 bit: out_feat equals FEATURES_PER_CC-1.

Function
REQ-015 The encoder binder SHALL be defined as a circular left rotate of the hypervector by S bits (bit i moves to bit (i+S) mod HV_DIM); this block SHALL perform the inverse, a circular right rotate of in_hv by S = SHIFTS[SHIFT_BASE+feat].
REQ-016 The rotate amount SHALL be reduced mod HV_DIM; S=0 and S=HV_DIM SHALL both pass the data through unchanged.
REQ-017 A transfer SHALL occur on an input when in_valid && in_ready, and on an output when out_valid && out_ready.
REQ-018 The datapath SHALL be a 2-stage pipeline: S1 registers in_hv, feat and S; S2 registers the rotated result, feat and last.
REQ-019 With no backpressure, an accepted beat SHALL appear on out_* exactly 2 cycles after its input transfer, giving a throughput of 1 beat per cycle.
REQ-020 S2 SHALL load when !s2_valid || out_ready; S1 SHALL advance when S2 loads.
REQ-021 in_ready SHALL equal !s1_valid || (S2 loads), and SHALL be combinational from out_ready.
REQ-022 While out_valid=1 and out_ready=0, out_hv, out_feat and out_last SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-023 The feature counter SHALL increment on each input transfer and wrap from FEATURES_PER_CC-1 to 0.
REQ-024 frame_clr=1 SHALL set the counter to 0 for the next transfer; if a transfer coincides with frame_clr, that beat SHALL use feature 0 and the counter SHALL become 1 (or 0 if FEATURES_PER_CC=1).
REQ-025 frame_clr SHALL NOT flush beats already held in S1 or S2.
REQ-026 The block SHALL contain no combinational path from in_* to out_*.

Reset
REQ-027 When rst=1, the block SHALL asynchronously clear s1_valid, s2_valid, out_valid and the feature counter to 0.
REQ-028 During reset, in_ready SHALL be 0 while rst is asserted and SHALL be 1 in the first cycle after release.
REQ-029 Data registers SHALL NOT be required to reset, but out_hv, out_feat and out_last SHALL read 0 after reset, before the first output.
REQ-030 A reset asserted mid-frame SHALL discard all in-flight beats, and the next accepted beat SHALL be feature 0.

Verification
REQ-031 Bench configuration: HV_DIM=16, FEATURES_PER_CC=4, SHIFTS[SHIFT_BASE..+3]={1,3,0,15}.
REQ-032 Scenario: stream 16'h0002, 16'h0008, 16'hA5A5, 16'h0001 with out_ready=1 -> out_hv 16'h0001, 16'h0001, 16'hA5A5, 16'h0002; out_feat 0,1,2,3; out_last only on the 4th beat; each beat 2 cycles after its input transfer.
REQ-033 Scenario: hold out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 beats accepted, then in_ready=0 and out_* stable; on out_ready=1, beats emerge in order with no loss.
REQ-034 Scenario: 6 consecutive beats -> out_feat 0,1,2,3,0,1 (wrap-around).
REQ-035 Scenario: frame_clr coincident with the 3rd transfer -> that beat has out_feat=0 and rotation 1; the next beat has out_feat=1.
REQ-036 Scenario: rst pulsed with 2 beats in flight -> out_valid drops immediately, no stale beat appears afterward, and the next beat has out_feat=0.
REQ-037 Scenario: chain enc_binder to this block for random in_hv with all feature indices -> out_hv equals the original level_hv.

Source files
------------

// File: rtl/dec_unbinder_stream.sv
// dec_unbinder_stream: undoes the encoder's per-feature left rotate by rotating each beat right by its table shift
// through a two-stage valid/ready pipeline that tracks the feature index within a frame.
package dec_unbinder_pkg;
    localparam int SHIFTS_N = 8;
    localparam int unsigned SHIFTS [SHIFTS_N] = '{1, 3, 0, 15, 16, 5, 2048, 7};
endpackage

module dec_unbinder_stream
    import dec_unbinder_pkg::*;
#(
    parameter int HV_DIM          = 2048,
    parameter int FEATURES_PER_CC = 8,
    parameter int SHIFT_BASE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [HV_DIM-1:0]     in_hv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HV_DIM-1:0]     out_hv,
    output logic [(FEATURES_PER_CC > 1 ? $clog2(FEATURES_PER_CC) : 1)-1:0] out_feat,
    output logic                  out_last
);
    localparam int FW  = FEATURES_PER_CC > 1 ? $clog2(FEATURES_PER_CC) : 1;
    localparam int SW  = HV_DIM > 1 ? $clog2(HV_DIM) : 1;
    localparam int SIW = SHIFTS_N > 1 ? $clog2(SHIFTS_N) : 1;

    // Table lookup by constant index keeps the rotate amount a small register, already reduced mod HV_DIM.
    function automatic logic [SW-1:0] shift_of(input logic [FW-1:0] f);
        int unsigned s;
        s = 0;
        for (int k = 0; k < SHIFTS_N; k++)
            if (k == SHIFT_BASE + int'(f)) s = SHIFTS[k[SIW-1:0]];
        return SW'(s % HV_DIM);
    endfunction

    logic [FW-1:0]     r_cnt;
    logic              r_s1_valid;
    logic [HV_DIM-1:0] r_s1_hv;
    logic [FW-1:0]     r_s1_feat;
    logic [SW-1:0]     r_s1_sh;
    logic              r_s2_valid;
    logic [HV_DIM-1:0] r_out_hv;
    logic [FW-1:0]     r_out_feat;
    logic              r_out_last;
    logic              w_s2_load;
    logic              w_in_xfer;
    logic [FW-1:0]     w_feat;
    logic [FW-1:0]     w_cnt_nxt;
    logic [HV_DIM-1:0] w_rot;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !rst && (!r_s1_valid || w_s2_load);
    assign w_in_xfer = in_valid && in_ready;
    assign w_feat    = frame_clr ? '0 : r_cnt;
    assign w_cnt_nxt = (int'(w_feat) == FEATURES_PER_CC - 1) ? '0 : w_feat + 1'b1;
    assign w_rot     = HV_DIM'({r_s1_hv, r_s1_hv} >> r_s1_sh);
    assign out_valid = r_s2_valid;
    assign out_hv    = r_out_hv;
    assign out_feat  = r_out_feat;
    assign out_last  = r_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_hv   <= '0;
            r_out_feat <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_in_xfer)
                r_cnt <= w_cnt_nxt;
            else if (frame_clr)
                r_cnt <= '0;
            if (in_ready)
                r_s1_valid <= in_valid;
            if (w_s2_load)
                r_s2_valid <= r_s1_valid;
            if (w_s2_load && r_s1_valid) begin
                r_out_hv   <= w_rot;
                r_out_feat <= r_s1_feat;
                r_out_last <= (int'(r_s1_feat) == FEATURES_PER_CC - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_hv   <= in_hv;
            r_s1_feat <= w_feat;
            r_s1_sh   <= shift_of(w_feat);
        end
    end
endmodule

// File: tb/tb_dec_unbinder_stream.sv
// tb_dec_unbinder_stream: directed streams checked every cycle against a queue model of the unbinder,
// plus literal expectations for the documented scenarios.
module tb_dec_unbinder_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_hv = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_hv;
    logic [1:0]  out_feat;
    logic        out_last;

    dec_unbinder_stream #(.HV_DIM(16), .FEATURES_PER_CC(4), .SHIFT_BASE(0)) dut (
        .clk(clk), .rst(rst), .frame_clr(frame_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_hv(in_hv),
        .out_valid(out_valid), .out_ready(out_ready), .out_hv(out_hv),
        .out_feat(out_feat), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] hv; int feat; logic last; int t;} beat_t;
    typedef struct {logic [15:0] hv; int feat; logic last; int lat;} rcv_t;

    int    sh [4] = '{1, 3, 0, 15};
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    cnt_m = 0;
    int    f_m;
    logic  seen_out = 1'b0;
    beat_t mq [$];
    rcv_t  recv [$];

    function automatic logic [15:0] rotr(input logic [15:0] v, input int s);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[(i + s) % 16];
        return r;
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[(i + s) % 16] = v[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: a beat is visible two cycles after acceptance unless an older beat is stalled.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            cnt_m = 0;
            seen_out = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_hv", out_hv, 0);
            chk("rst_out_feat", out_feat, 0);
            chk("rst_out_last", out_last, 0);
        end else begin
            chk("out_valid", out_valid, mq.size() > 0 && cyc >= mq[0].t + 2);
            chk("in_ready", in_ready, !(mq.size() >= 2 && !out_ready));
            if (!seen_out && !out_valid) begin
                chk("idle_out_hv", out_hv, 0);
                chk("idle_out_feat", out_feat, 0);
            end
            if (out_valid) seen_out = 1'b1;
            if (out_valid && mq.size() > 0) begin
                chk("out_hv", out_hv, mq[0].hv);
                chk("out_feat", out_feat, mq[0].feat);
                chk("out_last", out_last, mq[0].last);
            end
            if (out_valid && out_ready) begin
                recv.push_back('{out_hv, int'(out_feat), out_last, mq.size() > 0 ? cyc - mq[0].t : -1});
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (in_valid && in_ready) begin
                f_m = frame_clr ? 0 : cnt_m;
                mq.push_back('{rotr(in_hv, sh[f_m]), f_m, f_m == 3, cyc});
                cnt_m = (f_m + 1) % 4;
            end else if (frame_clr) begin
                cnt_m = 0;
            end
        end
    end

    task automatic send(input logic [15:0] v, input logic fc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_hv = v;
        frame_clr = fc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", mq.size(), 0);
    endtask

    task automatic pulse_clr();
        frame_clr = 1'b1;
        @(posedge clk);
        #1;
        frame_clr = 1'b0;
    endtask

    logic [15:0] lv [12];
    int          acc;
    int          feats6 [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1);
        @(posedge clk);
        #1;

        recv.delete();
        send(16'h0002, 1'b0);
        send(16'h0008, 1'b0);
        send(16'hA5A5, 1'b0);
        send(16'h0001, 1'b0);
        drain();
        chk("s1_count", recv.size(), 4);
        if (recv.size() == 4) begin
            chk("s1_hv0", recv[0].hv, 16'h0001);
            chk("s1_hv1", recv[1].hv, 16'h0001);
            chk("s1_hv2", recv[2].hv, 16'hA5A5);
            chk("s1_hv3", recv[3].hv, 16'h0002);
            for (int i = 0; i < 4; i++) begin
                chk("s1_feat", recv[i].feat, i);
                chk("s1_last", recv[i].last, i == 3);
                chk("s1_latency", recv[i].lat, 2);
            end
        end

        recv.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_hv = 16'h0004;
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            if (acc == 1) in_hv = 16'h0040;
            else if (acc == 2) in_hv = 16'h0100;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_accepted", acc, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_hold_hv", out_hv, 16'h0002);
        chk("stall_hold_feat", out_feat, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("stall_count", recv.size(), 2);
        if (recv.size() == 2) begin
            chk("stall_hv0", recv[0].hv, 16'h0002);
            chk("stall_hv1", recv[1].hv, 16'h0008);
            chk("stall_feat1", recv[1].feat, 1);
        end

        recv.delete();
        pulse_clr();
        for (int i = 0; i < 6; i++) send(16'h1111 * i + 16'h0001, 1'b0);
        drain();
        chk("wrap_count", recv.size(), 6);
        if (recv.size() == 6)
            for (int i = 0; i < 6; i++) chk("wrap_feat", recv[i].feat, feats6[i]);

        recv.delete();
        send(16'h1234, 1'b0);
        send(16'h00F0, 1'b0);
        send(16'h8001, 1'b1);
        send(16'h0010, 1'b0);
        drain();
        chk("clr_count", recv.size(), 4);
        if (recv.size() == 4) begin
            chk("clr_feat0", recv[0].feat, 2);
            chk("clr_feat1", recv[1].feat, 3);
            chk("clr_hv2", recv[2].hv, 16'hC000);
            chk("clr_feat2", recv[2].feat, 0);
            chk("clr_hv3", recv[3].hv, 16'h0002);
            chk("clr_feat3", recv[3].feat, 1);
        end

        recv.delete();
        out_ready = 1'b0;
        send(16'h0F0F, 1'b0);
        send(16'hF0F0, 1'b0);
        chk("inflight_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_beat", recv.size(), 0);
        send(16'h0002, 1'b0);
        drain();
        chk("post_rst_count", recv.size(), 1);
        if (recv.size() == 1) begin
            chk("post_rst_feat", recv[0].feat, 0);
            chk("post_rst_hv", recv[0].hv, 16'h0001);
        end

        recv.delete();
        pulse_clr();
        for (int i = 0; i < 12; i++) begin
            lv[i] = 16'($urandom);
            send(rotl(lv[i], sh[i % 4]), 1'b0);
        end
        drain();
        chk("chain_count", recv.size(), 12);
        if (recv.size() == 12)
            for (int i = 0; i < 12; i++) chk("chain_level", recv[i].hv, lv[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
